// File: rtl/cam_fill_ctrl.sv
// Miss-handling and fill controller in front of the cam cache: serves hits from the
// CAM, fetches misses from backing memory, writes them back, and owns victim choice and flush.
module cam_fill_ctrl #(
  parameter int WORDS     = 8,
  parameter int BITS      = 8,
  parameter int TAG_SZ    = 8,
  parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_SZ-1:0]    req_tag,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_data,
  output logic                 rsp_hit,
  output logic                 full,
  output logic [TAG_SZ-1:0]    cam_check_tag,
  output logic                 cam_read,
  input  logic                 cam_found_it,
  input  logic [BITS-1:0]      cam_data,
  output logic                 cam_write_,
  output logic [ADDR_LEFT:0]   cam_w_addr,
  output logic [BITS-1:0]      cam_wdata,
  output logic [TAG_SZ-1:0]    cam_new_tag,
  output logic                 cam_new_valid,
  output logic                 mem_req,
  output logic [TAG_SZ-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [BITS-1:0]      mem_rdata
);

  localparam int AW = ADDR_LEFT + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    FILL,
    RESP,
    FLUSH
  } state_t;

  state_t            r_state;
  logic [TAG_SZ-1:0] r_tag;
  logic [BITS-1:0]   r_data;
  logic              r_hit;
  logic [WORDS-1:0]  r_valid;
  logic [AW-1:0]     r_rrPtr;
  logic [AW-1:0]     r_idx;
  logic [AW-1:0]     w_victim;
  logic              w_allValid;
  logic [WORDS-1:0]  w_fillMask;

  assign req_ready  = (r_state == IDLE) && !flush;
  assign w_allValid = &r_valid;
  assign w_fillMask = WORDS'(1) << w_victim;

  // Lowest free slot wins; the round-robin pointer only matters once every slot is valid.
  always_comb begin
    w_victim = r_rrPtr;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_victim = AW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state       <= IDLE;
      r_tag         <= '0;
      r_data        <= '0;
      r_hit         <= 1'b0;
      r_valid       <= '0;
      r_rrPtr       <= '0;
      r_idx         <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_hit       <= 1'b0;
      full          <= 1'b0;
      cam_check_tag <= '0;
      cam_read      <= 1'b0;
      cam_write_    <= 1'b1;
      cam_w_addr    <= '0;
      cam_wdata     <= '0;
      cam_new_tag   <= '0;
      cam_new_valid <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state       <= FLUSH;
            r_idx         <= '0;
            cam_write_    <= 1'b0;
            cam_w_addr    <= '0;
            cam_wdata     <= '0;
            cam_new_tag   <= '0;
            cam_new_valid <= 1'b0;
          end else if (req_valid) begin
            r_state       <= LOOKUP;
            r_tag         <= req_tag;
            cam_check_tag <= req_tag;
            cam_read      <= 1'b1;
          end
        end
        LOOKUP: begin
          cam_read <= 1'b0;
          if (cam_found_it) begin
            r_state   <= RESP;
            r_data    <= cam_data;
            r_hit     <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= cam_data;
            rsp_hit   <= 1'b1;
          end else begin
            r_state  <= MISS_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= r_tag;
          end
        end
        MISS_WAIT: begin
          if (mem_ack) begin
            r_state       <= FILL;
            r_data        <= mem_rdata;
            r_hit         <= 1'b0;
            mem_req       <= 1'b0;
            cam_write_    <= 1'b0;
            cam_w_addr    <= w_victim;
            cam_wdata     <= mem_rdata;
            cam_new_tag   <= r_tag;
            cam_new_valid <= 1'b1;
          end
        end
        FILL: begin
          r_state       <= RESP;
          cam_write_    <= 1'b1;
          cam_new_valid <= 1'b0;
          r_valid       <= r_valid | w_fillMask;
          full          <= &(r_valid | w_fillMask);
          if (w_allValid) begin
            r_rrPtr <= (r_rrPtr == AW'(WORDS - 1)) ? '0 : r_rrPtr + 1'b1;
          end
          rsp_valid <= 1'b1;
          rsp_data  <= r_data;
          rsp_hit   <= r_hit;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state   <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        FLUSH: begin
          r_valid[r_idx] <= 1'b0;
          full           <= 1'b0;
          if (r_idx == AW'(WORDS - 1)) begin
            r_state    <= IDLE;
            r_rrPtr    <= '0;
            cam_write_ <= 1'b1;
          end else begin
            r_idx      <= r_idx + 1'b1;
            cam_w_addr <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Self-checking bench for cam_fill_ctrl: behavioural CAM and memory around the DUT,
// a reference cache model feeding a response scoreboard.
module tb_cam_fill_ctrl;

  logic       clk = 1'b0;
  logic       rst_;
  logic       req_valid, req_ready, flush;
  logic [7:0] req_tag;
  logic       rsp_valid, rsp_ready, rsp_hit, full;
  logic [7:0] rsp_data;
  logic [7:0] cam_check_tag, cam_data, cam_wdata, cam_new_tag;
  logic       cam_read, cam_found_it, cam_write_, cam_new_valid;
  logic [2:0] cam_w_addr;
  logic       mem_req, mem_ack;
  logic [7:0] mem_addr, mem_rdata;

  typedef struct {
    logic [7:0] data;
    logic       hit;
  } rspExp_t;

  rspExp_t    expQ[$];
  int         compareCount = 0;
  int         mismatchCount = 0;

  logic [7:0] refValid;
  logic [7:0] refTag [8];
  logic [2:0] refRr;

  logic [7:0] camValidM;
  logic [7:0] camTagM [8];
  logic [7:0] camDataM [8];

  always #5 clk = ~clk;

  cam_fill_ctrl dut (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .full(full),
    .cam_check_tag(cam_check_tag), .cam_read(cam_read), .cam_found_it(cam_found_it),
    .cam_data(cam_data), .cam_write_(cam_write_), .cam_w_addr(cam_w_addr),
    .cam_wdata(cam_wdata), .cam_new_tag(cam_new_tag), .cam_new_valid(cam_new_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Stand-in for the attached CAM: registered write port, combinational lookup.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      camValidM <= '0;
    end else if (!cam_write_) begin
      camValidM[cam_w_addr] <= cam_new_valid;
      camTagM[cam_w_addr]   <= cam_new_tag;
      camDataM[cam_w_addr]  <= cam_wdata;
    end
  end

  always_comb begin
    cam_found_it = 1'b0;
    cam_data     = '0;
    if (cam_read) begin
      for (int i = 0; i < 8; i++) begin
        if (camValidM[i] && camTagM[i] == cam_check_tag) begin
          cam_found_it = 1'b1;
          cam_data     = camDataM[i];
        end
      end
    end
  end

  function automatic logic [7:0] memWord(input logic [7:0] addr);
    return addr ^ 8'hB7;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
    end
  endtask

  task automatic clearModel();
    refValid = '0;
    refRr    = '0;
    for (int i = 0; i < 8; i++) refTag[i] = '0;
  endtask

  // Reference cache: predicts hit/miss, data and the slot a miss will be filled into.
  task automatic modelLookup(input logic [7:0] tag, output logic hit, output logic [7:0] data,
                             output logic [2:0] slot);
    hit  = 1'b0;
    slot = refRr;
    data = memWord(tag);
    for (int i = 0; i < 8; i++) begin
      if (refValid[i] && refTag[i] == tag) begin
        hit  = 1'b1;
        slot = 3'(i);
      end
    end
    if (!hit) begin
      if (&refValid) begin
        slot  = refRr;
        refRr = refRr + 3'd1;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          if (!refValid[i]) slot = 3'(i);
        end
      end
      refValid[slot] = 1'b1;
      refTag[slot]   = tag;
    end
  endtask

  task automatic waitReady();
    int waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!req_ready) checkOutput("reqReadyTimeout", 32'(req_ready), 1);
  endtask

  task automatic applyStimulus(input logic [7:0] tag, input int ackDelay, input int holdCycles);
    logic       expHit;
    logic [7:0] expData;
    logic [2:0] expSlot;
    rspExp_t    e;
    waitReady();
    modelLookup(tag, expHit, expData, expSlot);
    expQ.push_back('{data: expData, hit: expHit});
    req_valid = 1'b1;
    req_tag   = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("lookupRead", 32'(cam_read), 1);
    checkOutput("lookupTag", 32'(cam_check_tag), 32'(tag));
    @(posedge clk); #1;
    if (expHit) begin
      checkOutput("hitRspValid", 32'(rsp_valid), 1);
      checkOutput("hitNoMemReq", 32'(mem_req), 0);
    end else begin
      checkOutput("missMemReq", 32'(mem_req), 1);
      checkOutput("missMemAddr", 32'(mem_addr), 32'(tag));
      for (int d = 0; d < ackDelay; d++) begin
        @(posedge clk); #1;
        checkOutput("missHoldReq", 32'(mem_req), 1);
      end
      mem_ack   = 1'b1;
      mem_rdata = memWord(tag);
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      checkOutput("fillWrite", 32'(cam_write_), 0);
      checkOutput("fillAddr", 32'(cam_w_addr), 32'(expSlot));
      checkOutput("fillData", 32'(cam_wdata), 32'(expData));
      checkOutput("fillTag", 32'(cam_new_tag), 32'(tag));
      checkOutput("fillValid", 32'(cam_new_valid), 1);
      checkOutput("fillMemReqDrop", 32'(mem_req), 0);
      @(posedge clk); #1;
      checkOutput("fillRspValid", 32'(rsp_valid), 1);
      checkOutput("fillWriteDone", 32'(cam_write_), 1);
    end
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk); #1;
      checkOutput("holdRspValid", 32'(rsp_valid), 1);
      checkOutput("holdReqReady", 32'(req_ready), 0);
      checkOutput("holdRspData", 32'(rsp_data), 32'(expQ[0].data));
      checkOutput("holdRspHit", 32'(rsp_hit), 32'(expQ[0].hit));
    end
    rsp_ready = 1'b1;
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 1, 0);
    end else begin
      e = expQ.pop_front();
      checkOutput("rspValid", 32'(rsp_valid), 1);
      checkOutput("rspData", 32'(rsp_data), 32'(e.data));
      checkOutput("rspHit", 32'(rsp_hit), 32'(e.hit));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rspDrop", 32'(rsp_valid), 0);
    checkOutput("full", 32'(full), 32'(&refValid));
  endtask

  task automatic runFlush();
    waitReady();
    flush = 1'b1;
    #1;
    checkOutput("flushBlocksReady", 32'(req_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("flushWrite", 32'(cam_write_), 0);
      checkOutput("flushAddr", 32'(cam_w_addr), 32'(i));
      checkOutput("flushNewValid", 32'(cam_new_valid), 0);
      @(posedge clk); #1;
    end
    checkOutput("flushDone", 32'(cam_write_), 1);
    checkOutput("flushIdle", 32'(req_ready), 1);
    checkOutput("flushFull", 32'(full), 0);
    clearModel();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_      = 1'b0;
    req_valid = 1'b0;
    req_tag   = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    clearModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReqReady", 32'(req_ready), 1);
    checkOutput("rstRspValid", 32'(rsp_valid), 0);
    checkOutput("rstMemReq", 32'(mem_req), 0);
    checkOutput("rstCamWrite", 32'(cam_write_), 1);
    checkOutput("rstCamRead", 32'(cam_read), 0);
    checkOutput("rstFull", 32'(full), 0);
    rst_ = 1'b1;
    @(posedge clk); #1;

    applyStimulus(8'h12, 2, 0);
    applyStimulus(8'h12, 0, 5);
    runFlush();
    for (int t = 1; t <= 8; t++) applyStimulus(8'(t), t % 3, 0);
    applyStimulus(8'h09, 1, 0);
    applyStimulus(8'h01, 0, 0);
    applyStimulus(8'h05, 0, 3);
    runFlush();
    applyStimulus(8'h05, 1, 0);
    for (int r = 0; r < 14; r++) begin
      applyStimulus(8'(8'h10 + $urandom_range(0, 11)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)));
    end

    // Reset while waiting on memory: the pending request must vanish with no replay.
    waitReady();
    req_valid = 1'b1;
    req_tag   = 8'h33;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("midMemReq", 32'(mem_req), 1);
    rst_ = 1'b0;
    #1;
    checkOutput("midRstMemReq", 32'(mem_req), 0);
    checkOutput("midRstRspValid", 32'(rsp_valid), 0);
    checkOutput("midRstReqReady", 32'(req_ready), 1);
    checkOutput("midRstFull", 32'(full), 0);
    @(posedge clk); #1;
    rst_      = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'h5A;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("lateAckMemReq", 32'(mem_req), 0);
    checkOutput("lateAckRspValid", 32'(rsp_valid), 0);
    checkOutput("lateAckCamWrite", 32'(cam_write_), 1);
    @(posedge clk); #1;
    checkOutput("lateAckStillIdle", 32'(rsp_valid), 0);
    clearModel();
    applyStimulus(8'h33, 1, 0);
    applyStimulus(8'h33, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
